// File: rtl/mult_share_sched.sv
// Round-robin front end that time-shares one sequential signed shift-add multiplier
// between NUM_REQ requesters, with a watchdog that answers hung operations with an error.
module mult_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         ReqValid,
  output logic [NUM_REQ-1:0]         ReqReady,
  input  logic [NUM_REQ*WIDTH-1:0]   ReqA,
  input  logic [NUM_REQ*WIDTH-1:0]   ReqB,
  output logic [NUM_REQ-1:0]         RspValid,
  input  logic                       RspAccept,
  output logic [2*WIDTH-1:0]         RspProduct,
  output logic                       RspError,
  output logic                       MulReset,
  output logic [WIDTH-1:0]           MulMultiplicand,
  output logic [WIDTH-1:0]           MulMultiplier,
  input  logic [2*WIDTH-1:0]         MulProduct,
  input  logic                       MulHalt,
  output logic                       Busy
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_grant  = 3'd1,
    st_launch = 3'd2,
    st_clr    = 3'd3,
    st_run    = 3'd4,
    st_done   = 3'd5,
    st_resp   = 3'd6
  } state_t;

  state_t               state_r;
  logic [IW-1:0]        rr_r;
  logic [IW-1:0]        grant_r;
  logic [NUM_REQ-1:0]   ready_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [2*WIDTH-1:0]   rsp_prod_r;
  logic                 rsp_err_r;
  logic                 mul_rst_r;
  logic [WIDTH-1:0]     mul_a_r;
  logic [WIDTH-1:0]     mul_b_r;
  logic [WDW-1:0]       wd_r;
  logic                 busy_r;
  logic [IW-1:0]        pick_s;
  logic                 any_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      next_ptr = {IW{1'b0}};
    end else begin
      next_ptr = idx + IW'(1);
    end
  endfunction

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    idx    = 0;
    pick_s = rr_r;
    any_s  = |ReqValid;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_r) + i) % NUM_REQ;
      if (!found && ReqValid[idx]) begin
        found  = 1'b1;
        pick_s = IW'(idx);
      end else begin
        found  = found;
      end
    end
  end

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r     <= st_idle;
      rr_r        <= {IW{1'b0}};
      grant_r     <= {IW{1'b0}};
      ready_r     <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_prod_r  <= {(2*WIDTH){1'b0}};
      rsp_err_r   <= 1'b0;
      mul_rst_r   <= 1'b0;
      mul_a_r     <= {WIDTH{1'b0}};
      mul_b_r     <= {WIDTH{1'b0}};
      wd_r        <= {WDW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        st_idle: begin
          if (any_s) begin
            grant_r <= pick_s;
            ready_r <= onehot(pick_s);
            busy_r  <= 1'b1;
            state_r <= st_grant;
          end
        end
        st_grant: begin
          ready_r <= {NUM_REQ{1'b0}};
          if (ReqValid[grant_r]) begin
            mul_a_r   <= ReqA[int'(grant_r)*WIDTH +: WIDTH];
            mul_b_r   <= ReqB[int'(grant_r)*WIDTH +: WIDTH];
            rr_r      <= next_ptr(grant_r);
            mul_rst_r <= 1'b1;
            state_r   <= st_launch;
          end else begin
            busy_r  <= 1'b0;
            state_r <= st_idle;
          end
        end
        st_launch: begin
          mul_rst_r <= 1'b0;
          wd_r      <= {WDW{1'b0}};
          state_r   <= st_clr;
        end
        st_clr, st_run: begin
          if (wd_r == WDW'(TIMEOUT)) begin
            rsp_prod_r  <= {(2*WIDTH){1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= onehot(grant_r);
            state_r     <= st_resp;
          end else begin
            wd_r <= wd_r + WDW'(1);
            // A Halt still high from the previous op must first be seen to drop.
            if (state_r == st_clr && !MulHalt) begin
              state_r <= st_run;
            end else if (state_r == st_run && MulHalt) begin
              state_r <= st_done;
            end
          end
        end
        st_done: begin
          rsp_prod_r  <= MulProduct;
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= onehot(grant_r);
          state_r     <= st_resp;
        end
        st_resp: begin
          if (RspAccept) begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= st_idle;
          end
        end
        default: begin
          ready_r     <= {NUM_REQ{1'b0}};
          rsp_valid_r <= {NUM_REQ{1'b0}};
          mul_rst_r   <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= st_idle;
        end
      endcase
    end
  end

  assign ReqReady        = ready_r;
  assign RspValid        = rsp_valid_r;
  assign RspProduct      = rsp_prod_r;
  assign RspError        = rsp_err_r;
  assign MulReset        = mul_rst_r;
  assign MulMultiplicand = mul_a_r;
  assign MulMultiplier   = mul_b_r;
  assign Busy            = busy_r;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed and randomized bench for mult_share_sched with a behavioural multiplier
// and a round-robin / signed-product reference model.
module tb_mult_share_sched;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  valid = 4'b0000;
  logic [3:0]  ReqReady;
  logic [31:0] ReqA;
  logic [31:0] ReqB;
  logic [3:0]  RspValid;
  logic        RspAccept = 1'b0;
  logic [15:0] RspProduct;
  logic        RspError;
  logic        MulReset;
  logic [7:0]  MulMultiplicand;
  logic [7:0]  MulMultiplier;
  logic [15:0] MulProduct = 16'h0000;
  logic        MulHalt = 1'b1;
  logic        Busy;

  logic [7:0]  av [4];
  logic [7:0]  bv [4];
  int          checks = 0;
  int          errors = 0;
  int          ptr = 0;
  int          mr_cnt = 0;
  logic        stuck = 1'b0;
  logic [7:0]  ma = 8'h00;
  logic [7:0]  mb = 8'h00;
  logic [3:0]  cnt = 4'h0;

  assign ReqA = {av[3], av[2], av[1], av[0]};
  assign ReqB = {bv[3], bv[2], bv[1], bv[0]};

  mult_share_sched #(.NUM_REQ(4), .WIDTH(8), .TIMEOUT(63)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(valid), .ReqReady(ReqReady),
    .ReqA(ReqA), .ReqB(ReqB), .RspValid(RspValid), .RspAccept(RspAccept),
    .RspProduct(RspProduct), .RspError(RspError), .MulReset(MulReset),
    .MulMultiplicand(MulMultiplicand), .MulMultiplier(MulMultiplier),
    .MulProduct(MulProduct), .MulHalt(MulHalt), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Sequential multiplier stand-in: restart on MulReset, run a few cycles, raise Halt.
  always_ff @(posedge Clock) begin
    if (stuck) begin
      MulHalt    <= 1'b1;
      MulProduct <= 16'($urandom);
    end else if (MulReset) begin
      MulHalt <= 1'b0;
      cnt     <= 4'($urandom_range(9, 2));
      ma      <= MulMultiplicand;
      mb      <= MulMultiplier;
    end else if (!MulHalt) begin
      if (cnt == 4'h0) begin
        MulHalt    <= 1'b1;
        MulProduct <= 16'(int'($signed(ma)) * int'($signed(mb)));
      end else begin
        cnt <= cnt - 4'h1;
      end
    end
  end

  always_ff @(negedge Clock) begin
    if (MulReset) mr_cnt <= mr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    for (int i = 0; i < 4; i++) begin
      if (valid[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  task automatic rand_ops(input int i);
    av[i] = 8'($urandom);
    bv[i] = 8'($urandom);
  endtask

  // One complete operation: grant, transfer, response, optional held accept.
  task automatic service(input bit keep, input bit exp_err, input int hold, output int gidx);
    int ei; bit got; logic [3:0] er; logic [15:0] ep; int mr0;
    got = 1'b0; gidx = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clock);
      if (ReqReady !== 4'b0000) begin got = 1'b1; break; end
    end
    chk("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    ei = model_pick();
    er = (ei >= 0) ? (4'b0001 << ei) : 4'b0000;
    chk("grant_onehot", 32'(ReqReady), 32'(er));
    gidx = ei;
    if (ei < 0) return;
    ep  = exp_err ? 16'h0000 : 16'(int'($signed(av[ei])) * int'($signed(bv[ei])));
    ptr = (ei + 1) % 4;
    mr0 = mr_cnt;
    @(posedge Clock); #1;
    if (keep) rand_ops(ei); else valid[ei] = 1'b0;
    @(negedge Clock);
    chk("grant_one_cycle", 32'(ReqReady), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (RspValid !== 4'b0000) begin got = 1'b1; break; end
      @(negedge Clock);
    end
    chk("rsp_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("rsp_valid", 32'(RspValid), 32'(er));
    chk("rsp_product", 32'(RspProduct), 32'(ep));
    chk("rsp_error", 32'(RspError), 32'(exp_err));
    chk("mulreset_pulses", 32'(mr_cnt - mr0), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge Clock);
      chk("hold_valid", 32'(RspValid), 32'(er));
      chk("hold_product", 32'(RspProduct), 32'(ep));
      chk("hold_no_grant", 32'(ReqReady), 32'd0);
    end
    RspAccept = 1'b1;
    @(posedge Clock); #1;
    RspAccept = 1'b0;
  endtask

  initial begin
    int g; bit got; int mr0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) rand_ops(i);

    // Reset values
    repeat (3) @(negedge Clock);
    chk("rst_ready", 32'(ReqReady), 32'd0);
    chk("rst_rspvalid", 32'(RspValid), 32'd0);
    chk("rst_product", 32'(RspProduct), 32'd0);
    chk("rst_error", 32'(RspError), 32'd0);
    chk("rst_mulreset", 32'(MulReset), 32'd0);
    chk("rst_opa", 32'(MulMultiplicand), 32'd0);
    chk("rst_opb", 32'(MulMultiplier), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;
    ptr = 0;

    // Test 1: 7*6 on requester 0
    av[0] = 8'd7; bv[0] = 8'd6; valid[0] = 1'b1;
    service(1'b0, 1'b0, 0, g);
    @(negedge Clock);
    chk("t1_busy_after", 32'(Busy), 32'd0);

    // Grant withdrawn before transfer: no op, pointer unchanged
    valid[3] = 1'b1; mr0 = mr_cnt;
    @(posedge Clock); #1; valid[3] = 1'b0;
    @(negedge Clock);
    chk("drop_ready", 32'(ReqReady), 32'b1000);
    @(negedge Clock);
    chk("drop_busy", 32'(Busy), 32'd0);
    chk("drop_no_launch", 32'(mr_cnt - mr0), 32'd0);
    #1; valid = 4'b1001;
    service(1'b0, 1'b0, 0, g);
    chk("drop_ptr_kept", 32'(g), 32'd3);
    service(1'b0, 1'b0, 0, g);

    // Test 2: signed operands
    av[1] = 8'hFD; bv[1] = 8'd5; valid[1] = 1'b1;
    service(1'b0, 1'b0, 0, g);
    av[2] = 8'd4; bv[2] = 8'hFE; valid[2] = 1'b1;
    service(1'b0, 1'b0, 0, g);

    // Test 4: stuck multiplier hits the watchdog
    stuck = 1'b1;
    rand_ops(3); valid[3] = 1'b1;
    service(1'b0, 1'b1, 0, g);
    @(negedge Clock);
    chk("t4_busy_after", 32'(Busy), 32'd0);
    stuck = 1'b0;

    // Test 5: response held 10 cycles while another requester waits
    #1; rand_ops(0); rand_ops(2); valid = 4'b0101;
    service(1'b0, 1'b0, 10, g);
    service(1'b0, 1'b0, 0, g);

    // Randomized mix of contending requesters
    for (int k = 0; k < 12; k++) begin
      logic [3:0] nv;
      nv = 4'($urandom_range(15, 1));
      for (int i = 0; i < 4; i++) if (!valid[i] && nv[i]) rand_ops(i);
      valid = valid | nv;
      service(1'b0, 1'b0, int'($urandom_range(2, 0)), g);
    end
    for (int k = 0; k < 4; k++) if (valid != 4'b0000) service(1'b0, 1'b0, 0, g);

    // Test 6: reset while the multiplier is running
    @(negedge Clock);
    rand_ops(1); valid[1] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge Clock);
      if (ReqReady !== 4'b0000) begin got = 1'b1; break; end
    end
    chk("t6_grant", 32'(ReqReady), 32'b0010);
    @(posedge Clock); #1; valid[1] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge Clock);
      if (MulHalt === 1'b0) begin got = 1'b1; break; end
    end
    chk("t6_running", 32'(got), 32'd1);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("t6_ready", 32'(ReqReady), 32'd0);
    chk("t6_rspvalid", 32'(RspValid), 32'd0);
    chk("t6_product", 32'(RspProduct), 32'd0);
    chk("t6_error", 32'(RspError), 32'd0);
    chk("t6_mulreset", 32'(MulReset), 32'd0);
    chk("t6_ops", 32'({MulMultiplicand, MulMultiplier}), 32'd0);
    chk("t6_busy", 32'(Busy), 32'd0);
    Reset = 1'b1; ptr = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clock);
      chk("t6_no_rsp", 32'({RspValid, Busy}), 32'd0);
    end

    // Test 3: all requesters continuously valid from pointer 0
    for (int i = 0; i < 4; i++) rand_ops(i);
    valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      service(1'b1, 1'b0, 0, g);
      chk("t3_order", 32'(g), 32'(exp_order[k]));
    end
    valid = 4'b0000;
    repeat (3) @(negedge Clock);
    chk("t3_idle", 32'({Busy, ReqReady}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
